// File: rtl/booth_divider_8bit_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// The master side issues start with operands; the slave side returns results with busy/done.
interface booth_divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic [WIDTH-1:0] quotient_out;
    logic [WIDTH-1:0] remainder_out;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend_in, divisor_in,
        input  quotient_out, remainder_out, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend_in, divisor_in,
        output quotient_out, remainder_out, busy, done, div_by_zero
    );
endinterface

// File: rtl/booth_divider_8bit.sv
// Sequential signed divider: magnitude non-restoring loop, one radix-2 step per clock,
// followed by a single fix-up cycle that corrects the remainder and applies the signs.
module booth_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_divider_8bit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   p_sh, p_step;
    logic [WIDTH-1:0] rem_mag;

    always_comb begin
        a_mag = bus.dividend_in[WIDTH-1] ? (WIDTH'(0) - bus.dividend_in) : bus.dividend_in;
        b_mag = bus.divisor_in[WIDTH-1]  ? (WIDTH'(0) - bus.divisor_in)  : bus.divisor_in;

        // P stays within [-D, D) so WIDTH+1 bits suffice even for D = 2^(WIDTH-1).
        p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        p_step = p_q[WIDTH] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});

        // Corrected remainder is below D, so only the low WIDTH bits are needed.
        rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        q_d       = q_q;
        d_d       = d_q;
        dvd_d     = dvd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d     = bus.dividend_in;
                    neg_quo_d = bus.dividend_in[WIDTH-1] ^ bus.divisor_in[WIDTH-1];
                    neg_rem_d = bus.dividend_in[WIDTH-1];
                    q_d       = a_mag;
                    d_d       = b_mag;
                    p_d       = '0;
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    zero_d    = (bus.divisor_in == '0);
                    state_d   = (bus.divisor_in == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = dvd_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = neg_quo_q ? (WIDTH'(0) - q_q) : q_q;
                    rem_d  = neg_rem_q ? (WIDTH'(0) - rem_mag) : rem_mag;
                    dbz_d  = 1'b0;
                end
                p_d     = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            q_q       <= q_d;
            d_q       <= d_d;
            dvd_q     <= dvd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.quotient_out  = quot_q;
    assign bus.remainder_out = rem_q;
    assign bus.div_by_zero   = dbz_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_booth_divider_8bit.sv
// Directed bench for booth_divider_8bit: hand-computed quotients/remainders, latency,
// busy/done handshake, ignored starts, held start, zero divide and mid-operation reset.
module tb_booth_divider_8bit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_divider_8bit_if #(.WIDTH(W)) bus ();

    booth_divider_8bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive operands with start for exactly one edge; returns sampled #1 after that edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.dividend_in = a;
        bus.divisor_in  = b;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the current point until done is seen (bounded), plus busy cycles.
    task automatic wait_done(output int n, output int busy_cnt);
        n = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic div_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz, input int elat);
        int n, bc;
        launch(a, b);
        wait_done(n, bc);
        chk({tag, " latency"}, n, elat);
        chk({tag, " quotient"}, bus.quotient_out, eq);
        chk({tag, " remainder"}, bus.remainder_out, er);
        chk({tag, " div_by_zero"}, bus.div_by_zero, edbz);
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int n, bc, seen;
        bus.start       = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset quotient", bus.quotient_out, 8'h00);
        chk("reset remainder", bus.remainder_out, 8'h00);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset dbz", bus.div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 100 / 7: done visible after edge k+9 (10 edges including the start edge).
        launch(8'd100, 8'd7);
        wait_done(n, bc);
        chk("100/7 latency", n, 9);
        chk("100/7 busy cycles", bc, 9);
        chk("100/7 quotient", bus.quotient_out, 8'h0E);
        chk("100/7 remainder", bus.remainder_out, 8'h02);
        chk("100/7 dbz", bus.div_by_zero, 1'b0);
        @(posedge clk);
        #1;
        chk("100/7 done pulse", bus.done, 1'b0);
        chk("100/7 hold quotient", bus.quotient_out, 8'h0E);

        div_check("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 9);
        div_check("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9);
        div_check("-100/-7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 9);
        div_check("50/0", 8'd50, 8'd0, 8'hFF, 8'h32, 1'b1, 1);
        div_check("10/3", 8'd10, 8'd3, 8'h03, 8'h01, 1'b0, 9);
        div_check("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
        div_check("-128/1", 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 9);
        div_check("5/9", 8'd5, 8'd9, 8'h00, 8'h05, 1'b0, 9);
        div_check("127/127", 8'd127, 8'd127, 8'h01, 8'h00, 1'b0, 9);

        // Start re-pulsed mid-operation with new operands must be ignored.
        launch(8'd100, 8'd7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.dividend_in = 8'd20;
        bus.divisor_in  = 8'd4;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n, bc);
        chk("ignored start latency", n + 3, 9);
        chk("ignored start quotient", bus.quotient_out, 8'h0E);
        chk("ignored start remainder", bus.remainder_out, 8'h02);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("ignored start no relaunch", bus.busy, 1'b0);

        // Start held high: the next operation is accepted on the edge after done.
        @(negedge clk);
        bus.dividend_in = 8'd100;
        bus.divisor_in  = 8'd7;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.dividend_in = 8'd10;
        bus.divisor_in  = 8'd3;
        wait_done(n, bc);
        chk("held start first latency", n, 9);
        chk("held start first quotient", bus.quotient_out, 8'h0E);
        chk("held start first busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("held start reaccept busy", bus.busy, 1'b1);
        chk("held start reaccept done", bus.done, 1'b0);
        wait_done(n, bc);
        chk("held start second latency", n, 9);
        chk("held start second quotient", bus.quotient_out, 8'h03);
        chk("held start second remainder", bus.remainder_out, 8'h01);

        // Asynchronous reset mid-operation: outputs clear immediately, no done afterwards.
        launch(8'd100, 8'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        chk("abort quotient", bus.quotient_out, 8'h00);
        chk("abort remainder", bus.remainder_out, 8'h00);
        chk("abort busy", bus.busy, 1'b0);
        chk("abort done", bus.done, 1'b0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("abort no done", seen, 0);
        div_check("81/9", 8'd81, 8'd9, 8'h09, 8'h00, 1'b0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
